mod_down_counter: RTL and testbench

- Modulo-N down counter, the counting-direction complement of the team's hardcoded mod up counter.
- Counts from (modulus−1) down to 0 while enabled, then reloads.
- Modulus is runtime-loadable up to the compile-time MOD.
- Drives a terminal-count flag and a registered wrap pulse, so timers and prescalers can be chained off it.

---
 rtl/mod_counter_pkg.sv | 18 +
 rtl/mod_down_counter.sv | 104 ++++++++++
 tb/tb_mod_down_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counters (up and down variants).
//   MOD_DEFAULT  : default maximum modulus used by the counters and benches
//   state_e      : counter control state (DONE only reachable in one-shot builds)
//   clamp_start  : limits a requested start value to mod-1
package mod_counter_pkg;

    localparam int MOD_DEFAULT = 11;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1
    } state_e;

    function automatic int clamp_start(input int val, input int mod);
        return (val > mod - 1) ? mod - 1 : val;
    endfunction

endpackage

// File: rtl/mod_down_counter.sv
// Modulo-N down counter with runtime-loadable modulus.
// Counts from start value (modulus-1) down to 0 on each enabled clock, then
// reloads. tc flags the cycle that will wrap; wrap pulses the cycle after.
// Optional one-shot mode (macro MOD_DOWN_COUNTER_ONESHOT_EN): stops at 0
// instead of reloading and raises done until the next load or reset.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   enable    decrement strobe
//   load      load start value from load_val (wins over enable)
//   load_val  requested start value, clamped to MOD-1
//   Q         current count
//   tc        combinational terminal count (this cycle wraps)
//   wrap      registered one-cycle pulse after a wrap
//   oneshot   (one-shot build) stop at 0 instead of reloading
//   done      (one-shot build) high while stopped at 0
module mod_down_counter
    import mod_counter_pkg::*;
#(
    parameter  int MOD  = MOD_DEFAULT,
    localparam int BITS = $clog2(MOD)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
    input  logic            oneshot,
    output logic            done,
`endif
    output logic [BITS-1:0] Q,
    output logic            tc,
    output logic            wrap
);

    localparam logic [BITS-1:0] MAX_V = BITS'(MOD - 1);

    logic [BITS-1:0] q_q, q_d;
    logic [BITS-1:0] start_q, start_d;
    logic            wrap_q, wrap_d;
    logic            run;

`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
    state_e state_q, state_d;
    assign run  = (state_q == RUN);
    assign done = (state_q == DONE);
`else
    assign run = 1'b1;
`endif

    always_comb begin
        q_d     = q_q;
        start_d = start_q;
        wrap_d  = 1'b0;
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
        state_d = state_q;
`endif
        if (load) begin
            start_d = BITS'(clamp_start(int'(load_val), MOD));
            q_d     = start_d;
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
            state_d = RUN;
`endif
        end else if (enable && run) begin
            if (q_q != '0) begin
                q_d = q_q - BITS'(1);
            end else begin
                wrap_d = 1'b1;
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
                // One-shot: park at 0 rather than reloading.
                if (oneshot) state_d = DONE;
                else         q_d     = start_q;
`else
                q_d = start_q;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= MAX_V;
            start_q <= MAX_V;
            wrap_q  <= 1'b0;
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
            state_q <= RUN;
`endif
        end else begin
            q_q     <= q_d;
            start_q <= start_d;
            wrap_q  <= wrap_d;
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
            state_q <= state_d;
`endif
        end
    end

    // A load or reset on this edge means no wrap happens, so tc stays low.
    assign tc   = (q_q == '0) & enable & ~load & ~reset & run;
    assign Q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_down_counter.sv
module tb_mod_down_counter;
    import mod_counter_pkg::*;

    localparam int MOD  = MOD_DEFAULT;
    localparam int BITS = $clog2(MOD);

    logic            clk = 1'b0;
    logic            reset, enable, load;
    logic [BITS-1:0] load_val;
    logic [BITS-1:0] Q;
    logic            tc, wrap;
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
    logic            oneshot, done;
`endif

    int n_vec = 0;
    int n_err = 0;

    mod_down_counter #(.MOD(MOD)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .load     (load),
        .load_val (load_val),
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
        .oneshot  (oneshot),
        .done     (done),
`endif
        .Q        (Q),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each check waits 1ns so freshly driven inputs have settled into tc.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #1;
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        reset = 1'b1; enable = 1'b0; load = 1'b0; load_val = '0;
`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
        oneshot = 1'b0;
`endif
        tick();
        chk("rst_q", 32'(Q), 10);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_tc", 32'(tc), 0);
        reset = 1'b0;

        // Full period at default modulus: 10..0 then 10.
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            e = (i == 11) ? 10 : 10 - i;
            chk("p11_q", 32'(Q), 32'(e));
            chk("p11_tc", 32'(tc), (i == 10) ? 1 : 0);
            chk("p11_wrap", 32'(wrap), (i == 11) ? 1 : 0);
            tick();
        end
        chk("p11_end_q", 32'(Q), 9);

        // Load 3: period of 4.
        enable = 1'b0; load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0;
        chk("ld3_q", 32'(Q), 3);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = 3 - (i % 4);
            chk("p4_q", 32'(Q), 32'(e));
            chk("p4_tc", 32'(tc), (e == 0) ? 1 : 0);
            chk("p4_wrap", 32'(wrap), (i == 4) ? 1 : 0);
            tick();
        end
        chk("p4_end_q", 32'(Q), 3);
        chk("p4_end_wrap", 32'(wrap), 1);

        // Load above MOD-1 clamps to 10.
        enable = 1'b0; load = 1'b1; load_val = 4'd14;
        tick();
        load = 1'b0;
        chk("clamp_q", 32'(Q), 10);
        enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            chk("clamp_cnt_q", 32'(Q), 32'(10 - i));
            chk("clamp_tc", 32'(tc), (i == 10) ? 1 : 0);
            tick();
        end
        chk("clamp_wrap_q", 32'(Q), 10);
        chk("clamp_wrap", 32'(wrap), 1);
        enable = 1'b0;
        tick();
        chk("hold_q", 32'(Q), 10);
        chk("hold_wrap", 32'(wrap), 0);

        // Drive to 0, then load and enable together: load wins, no tc.
        enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        enable = 1'b0;
        chk("zero_q", 32'(Q), 0);
        chk("zero_tc_dis", 32'(tc), 0);
        enable = 1'b1; load = 1'b1; load_val = 4'd5;
        chk("ldq0_tc", 32'(tc), 0);
        tick();
        chk("ldq0_q", 32'(Q), 5);
        chk("ldq0_wrap", 32'(wrap), 0);

        // Modulus 1: tc every enabled cycle, wrap every following cycle.
        enable = 1'b0; load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("m1_q", 32'(Q), 0);
            chk("m1_tc", 32'(tc), 1);
            tick();
            chk("m1_wrap", 32'(wrap), 1);
        end
        enable = 1'b0;
        tick();
        chk("m1_off_wrap", 32'(wrap), 0);

        // Reset mid-count discards loaded modulus.
        load = 1'b1; load_val = 4'd6;
        tick();
        load = 1'b0; enable = 1'b1;
        tick(); tick();
        chk("pre_rst_q", 32'(Q), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_q", 32'(Q), 10);
        chk("mid_rst_wrap", 32'(wrap), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("mid_rst_q0", 32'(Q), 0);
        tick();
        chk("mid_rst_reload", 32'(Q), 10);
        chk("mid_rst_rwrap", 32'(wrap), 1);

        // Reset outranks load.
        reset = 1'b1; load = 1'b1; load_val = 4'd2;
        chk("rst_ld_tc", 32'(tc), 0);
        tick();
        reset = 1'b0; load = 1'b0;
        chk("rst_ld_q", 32'(Q), 10);

`ifdef MOD_DOWN_COUNTER_ONESHOT_EN
        // One-shot: stop at 0, done latched until next load.
        enable = 1'b0; oneshot = 1'b1; load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("os_q", 32'(Q), (i < 2) ? 32'(2 - i) : 0);
            chk("os_tc", 32'(tc), (i == 2) ? 1 : 0);
            chk("os_done", 32'(done), (i >= 3) ? 1 : 0);
            chk("os_wrap", 32'(wrap), (i == 3) ? 1 : 0);
            tick();
        end
        load = 1'b1; load_val = 4'd5;
        tick();
        load = 1'b0;
        chk("os_ld_done", 32'(done), 0);
        chk("os_ld_q", 32'(Q), 5);
        tick();
        chk("os_resume_q", 32'(Q), 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
